// File: rtl/mio_ready_resp.sv
// CPU-side MIO bus responder: captures a CPU_MIO request, inserts address-dependent
// wait states, strobes writes / latches reads, then holds MIO_ready (four-phase).
// Optional ACK-phase timeout enabled by defining MIO_RESP_TIMEOUT_EN.
module mio_ready_resp #(
    parameter logic [3:0] RAM_WAIT = 4'd1,
    parameter logic [3:0] IO_WAIT  = 4'd2,
    parameter int         TO_LIMIT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        CPU_MIO,
    input  logic        mem_w,
    input  logic [31:0] Addr_out,
    input  logic [31:0] Data_out,
    input  logic [31:0] bus_rdata,
    output logic        MIO_ready,
    output logic [31:0] Data_in,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic        bus_mem_w,
    output logic        busy,
    output logic        timeout_err
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

    state_t      state, state_nxt;
    logic [3:0]  cnt;
    logic        wr_flag;
    logic        armed;
    logic        capture;
    logic        to_hit;

    function automatic logic [3:0] wait_for(input logic [31:0] addr);
        return (addr[31:28] >= 4'hE) ? IO_WAIT : RAM_WAIT;
    endfunction

    // A request is only accepted once CPU_MIO has been seen low since the last capture
    assign capture   = (state == S_IDLE) && CPU_MIO && armed;
    assign bus_mem_w = (state == S_WAIT) && (cnt == 4'd0) && wr_flag;
    assign MIO_ready = (state == S_ACK);
    assign busy      = (state != S_IDLE);

`ifdef MIO_RESP_TIMEOUT_EN
    localparam logic [7:0] TO_LAST = 8'(TO_LIMIT - 1);
    logic [7:0] to_cnt;

    assign to_hit = (state == S_ACK) && CPU_MIO && (to_cnt == TO_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            to_cnt      <= 8'd0;
            timeout_err <= 1'b0;
        end else begin
            to_cnt <= (state == S_ACK) ? to_cnt + 8'd1 : 8'd0;
            if (to_hit)
                timeout_err <= 1'b1;
        end
    end
`else
    assign to_hit      = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (capture) state_nxt = S_WAIT;
            S_WAIT: begin
                if (!CPU_MIO)
                    state_nxt = S_IDLE;
                else if (cnt == 4'd0)
                    state_nxt = S_ACK;
            end
            S_ACK:  if (!CPU_MIO || to_hit) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            cnt       <= 4'd0;
            wr_flag   <= 1'b0;
            armed     <= 1'b1;
            bus_addr  <= 32'd0;
            bus_wdata <= 32'd0;
            Data_in   <= 32'd0;
        end else begin
            state <= state_nxt;
            if (!CPU_MIO)
                armed <= 1'b1;
            if (capture) begin
                bus_addr  <= Addr_out;
                bus_wdata <= Data_out;
                wr_flag   <= mem_w;
                cnt       <= wait_for(Addr_out);
                armed     <= 1'b0;
            end
            // Abort (CPU_MIO low) freezes the counter and leaves Data_in untouched
            if (state == S_WAIT && CPU_MIO) begin
                if (cnt != 4'd0)
                    cnt <= cnt - 4'd1;
                else if (!wr_flag)
                    Data_in <= bus_rdata;
            end
        end
    end

endmodule

// File: tb/tb_mio_ready_resp.sv
// Directed testbench for mio_ready_resp (RAM_WAIT=1, IO_WAIT=2, TO_LIMIT=4).
module tb_mio_ready_resp;

    logic        clk = 1'b0;
    logic        rst;
    logic        CPU_MIO;
    logic        mem_w;
    logic [31:0] Addr_out;
    logic [31:0] Data_out;
    logic [31:0] bus_rdata;
    logic        MIO_ready;
    logic [31:0] Data_in;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_mem_w;
    logic        busy;
    logic        timeout_err;

    int n_chk  = 0;
    int n_fail = 0;

`ifdef MIO_RESP_TIMEOUT_EN
    localparam int HOLD = 4;
`else
    localparam int HOLD = 5;
`endif

    mio_ready_resp #(.RAM_WAIT(4'd1), .IO_WAIT(4'd2), .TO_LIMIT(4)) dut (
        .clk(clk), .rst(rst), .CPU_MIO(CPU_MIO), .mem_w(mem_w),
        .Addr_out(Addr_out), .Data_out(Data_out), .bus_rdata(bus_rdata),
        .MIO_ready(MIO_ready), .Data_in(Data_in), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_mem_w(bus_mem_w), .busy(busy),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic request(input logic wr, input logic [31:0] a, input logic [31:0] d);
        CPU_MIO = 1'b1; mem_w = wr; Addr_out = a; Data_out = d;
    endtask

    // RAM read with W=1: capture at k, MIO_ready at k+2
    task automatic ram_read(input string tag, input logic [31:0] a, input logic [31:0] rd);
        bus_rdata = rd;
        request(1'b0, a, 32'h0);
        step();
        check({tag, "_busy"}, {31'd0, busy}, 32'd1);
        check({tag, "_addr"}, bus_addr, a);
        check({tag, "_rdy_k"}, {31'd0, MIO_ready}, 32'd0);
        step();
        check({tag, "_rdy_k1"}, {31'd0, MIO_ready}, 32'd0);
        check({tag, "_strb_k1"}, {31'd0, bus_mem_w}, 32'd0);
        step();
        check({tag, "_rdy_k2"}, {31'd0, MIO_ready}, 32'd1);
        check({tag, "_data"}, Data_in, rd);
        check({tag, "_strb_k2"}, {31'd0, bus_mem_w}, 32'd0);
    endtask

    initial begin
        rst = 1'b1; CPU_MIO = 1'b0; mem_w = 1'b0;
        Addr_out = '0; Data_out = '0; bus_rdata = '0;
        step(); step();
        check("rst_rdy",  {31'd0, MIO_ready}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_strb", {31'd0, bus_mem_w}, 32'd0);
        check("rst_din",  Data_in, 32'd0);
        check("rst_addr", bus_addr, 32'd0);
        check("rst_wdat", bus_wdata, 32'd0);
        check("rst_to",   {31'd0, timeout_err}, 32'd0);
        rst = 1'b0;
        step();

        // Read, RAM region
        ram_read("rd1", 32'h0000_0010, 32'hDEAD_BEEF);
        CPU_MIO = 1'b0;
        step();
        check("rd1_rdy_drop", {31'd0, MIO_ready}, 32'd0);
        check("rd1_idle", {31'd0, busy}, 32'd0);

        // Write, I/O region; CPU inputs change after capture
        request(1'b1, 32'hE000_0000, 32'h0000_00FF);
        step();
        check("wr_addr", bus_addr, 32'hE000_0000);
        check("wr_wdat", bus_wdata, 32'h0000_00FF);
        check("wr_strb_c1", {31'd0, bus_mem_w}, 32'd0);
        Addr_out = 32'h0000_1234; Data_out = 32'h0;
        step();
        check("wr_strb_c2", {31'd0, bus_mem_w}, 32'd0);
        step();
        check("wr_strb_c3", {31'd0, bus_mem_w}, 32'd1);
        check("wr_rdy_c3", {31'd0, MIO_ready}, 32'd0);
        step();
        check("wr_rdy", {31'd0, MIO_ready}, 32'd1);
        check("wr_strb_ack", {31'd0, bus_mem_w}, 32'd0);
        check("wr_din_hold", Data_in, 32'hDEAD_BEEF);
        check("wr_addr_hold", bus_addr, 32'hE000_0000);
        check("wr_wdat_hold", bus_wdata, 32'h0000_00FF);
        CPU_MIO = 1'b0;
        step();

        // Abort after one WAIT cycle
        request(1'b1, 32'hF000_0000, 32'h0000_0055);
        step();
        step();
        check("ab_strb_w1", {31'd0, bus_mem_w}, 32'd0);
        CPU_MIO = 1'b0;
        step();
        check("ab_idle", {31'd0, busy}, 32'd0);
        check("ab_strb", {31'd0, bus_mem_w}, 32'd0);
        check("ab_rdy",  {31'd0, MIO_ready}, 32'd0);
        step();
        check("ab_strb2", {31'd0, bus_mem_w}, 32'd0);
        check("ab_rdy2",  {31'd0, MIO_ready}, 32'd0);
        check("ab_din",   Data_in, 32'hDEAD_BEEF);

        // Held request: MIO_ready stays up, no recapture while held
        ram_read("hold", 32'h0000_0020, 32'h1234_5678);
        Addr_out = 32'h0000_0040;
        for (int i = 1; i < HOLD; i++) begin
            step();
            check("hold_rdy", {31'd0, MIO_ready}, 32'd1);
            check("hold_addr", bus_addr, 32'h0000_0020);
        end
        CPU_MIO = 1'b0;
        step();
        check("hold_rdy_drop", {31'd0, MIO_ready}, 32'd0);
        check("hold_idle", {31'd0, busy}, 32'd0);

        // Reset during WAIT
        request(1'b1, 32'hE000_0008, 32'h0000_00AA);
        step();
        check("rw_busy", {31'd0, busy}, 32'd1);
        #1 rst = 1'b1;
        #1;
        check("rw_busy0", {31'd0, busy}, 32'd0);
        check("rw_strb0", {31'd0, bus_mem_w}, 32'd0);
        check("rw_rdy0",  {31'd0, MIO_ready}, 32'd0);
        check("rw_addr0", bus_addr, 32'd0);
        check("rw_wdat0", bus_wdata, 32'd0);
        check("rw_din0",  Data_in, 32'd0);
        CPU_MIO = 1'b0;
        step(); step();
        check("rw_strb_hold", {31'd0, bus_mem_w}, 32'd0);
        rst = 1'b0;
        step();
        ram_read("rd2", 32'h0000_0010, 32'hDEAD_BEEF);
        CPU_MIO = 1'b0;
        step();
        check("rd2_idle", {31'd0, busy}, 32'd0);

`ifdef MIO_RESP_TIMEOUT_EN
        // Timeout: ACK forced to IDLE after 4 cycles, no recapture while held
        ram_read("to", 32'h0000_0050, 32'h0BAD_F00D);
        for (int i = 1; i < 4; i++) begin
            step();
            check("to_rdy", {31'd0, MIO_ready}, 32'd1);
        end
        step();
        check("to_rdy0", {31'd0, MIO_ready}, 32'd0);
        check("to_err",  {31'd0, timeout_err}, 32'd1);
        check("to_idle", {31'd0, busy}, 32'd0);
        step();
        check("to_norecap", {31'd0, busy}, 32'd0);
        CPU_MIO = 1'b0;
        step();
        CPU_MIO = 1'b1;
        step();
        check("to_recap", {31'd0, busy}, 32'd1);
        check("to_sticky", {31'd0, timeout_err}, 32'd1);
        CPU_MIO = 1'b0;
        step();
        rst = 1'b1;
        #1;
        check("to_clr", {31'd0, timeout_err}, 32'd0);
        rst = 1'b0;
`else
        check("to_tied0", {31'd0, timeout_err}, 32'd0);
`endif
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/mio_ready_resp.md
# mio_ready_resp

Bus responder on the CPU side of the MIO bus: it is the slave end of the `CPU_MIO` / `MIO_ready` handshake issued by the multi-cycle CPU.
- Captures each CPU request and inserts address-dependent wait states: RAM region vs. GPIO/counter region.
- Issues a single-cycle qualified write strobe toward `MIO_BUS`.
- Latches read data, then raises `MIO_ready` until the CPU withdraws the request (four-phase).
- Sits between `m_cpu` and `MIO_BUS`, so the CPU never samples block-RAM or peripheral data before it is valid.

## Interface
Parameters:
- `RAM_WAIT`, 1, extra wait cycles for addresses outside the I/O region (0–15).
- `IO_WAIT`, 2, extra wait cycles for I/O region `addr[31:28]` = 4'hE or 4'hF (0–15).
- `TO_LIMIT`, 255, ACK-phase timeout in cycles (only with `MIO_RESP_TIMEOUT_EN`).

Ports:
- `clk` in 1: CPU clock; all state changes on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `CPU_MIO` in 1: CPU request; held high until `MIO_ready` is seen.
- `mem_w` in 1: request is a write.
- `Addr_out` in 32: CPU address.
- `Data_out` in 32: CPU write data.
- `bus_rdata` in 32: read data from `MIO_BUS` (`Cpu_data4bus`).
- `MIO_ready` out 1: transfer complete.
- `Data_in` out 32: latched read data to CPU.
- `bus_addr` out 32: captured address to `MIO_BUS`.
- `bus_wdata` out 32: captured write data.
- `bus_mem_w` out 1: single-cycle write strobe.
- `busy` out 1: high in any state but IDLE.
- `timeout_err` out 1: sticky timeout flag.

## Operation
- States: IDLE, WAIT, ACK.
- **IDLE:**
  - On `CPU_MIO`=1, capture `Addr_out`→`bus_addr`, `Data_out`→`bus_wdata` and `mem_w` into an internal write flag.
  - Load the 4-bit wait counter with `IO_WAIT` if `Addr_out[31:28]`≥4'hE, else `RAM_WAIT`.
  - Go to WAIT.
- **WAIT:**
  - While count > 0: decrement.
  - At count = 0:
    - Write: assert `bus_mem_w` for that one cycle.
    - Read: latch `bus_rdata` into `Data_in` at the end of the cycle.
  - Then go to ACK.
- **ACK:** `MIO_ready`=1; when `CPU_MIO`=0, go to IDLE, with `MIO_ready` dropping at the same edge.
- **Abort:** `CPU_MIO`=0 during WAIT returns to IDLE next edge. No write strobe is issued if count had not reached 0. `Data_in` is unchanged.
- **Captured values:** `bus_addr` and `bus_wdata` stay constant from capture until the next request is captured. Changes on CPU inputs after capture are ignored.
- **Writes:** `Data_in` holds its previous value.
- **Back-to-back:** a new request requires at least one IDLE cycle with `CPU_MIO` sampled high. `CPU_MIO` held high across ACK→IDLE is not a new request until it has been seen low.

## Timing
- Request sampled at edge k → WAIT.
- With wait value W:
  - `bus_mem_w` (write) is high in cycle k+W+1.
  - Read data is latched at edge k+W+1.
  - `MIO_ready` rises at edge k+W+1 and stays high until `CPU_MIO` is sampled low.
- Minimum latency (W=0): `MIO_ready` one cycle after request capture.
- Reset values:
  - State IDLE; counter 0.
  - `MIO_ready`, `bus_mem_w`, `busy`, `timeout_err` = 0.
  - `Data_in`, `bus_addr`, `bus_wdata` = 0.
- Reset mid-transfer aborts immediately and asynchronously; no strobe is issued after reset assertion.

## Configuration
- `MIO_RESP_TIMEOUT_EN` defined:
  - An 8-bit counter runs in ACK.
  - If `CPU_MIO` stays high for `TO_LIMIT` cycles after ACK entry, force IDLE and set `timeout_err`.
  - `timeout_err` is sticky until `rst`.
  - Forced-idle entry re-arms the edge requirement: `CPU_MIO` must be seen low before a new capture.
- Not defined: ACK is held indefinitely; `timeout_err` is tied 0; no counter is instantiated.

## Test plan
- **Read, RAM region:** RAM_WAIT=1, read at 0x0000_0010, `bus_rdata`=0xDEADBEEF → `MIO_ready` 2 edges after capture, `Data_in`=0xDEADBEEF, `bus_mem_w` never high.
- **Write, I/O region:** IO_WAIT=2, write 0x0000_00FF to 0xE000_0000 → `bus_mem_w` high exactly one cycle (3rd cycle after capture), `bus_addr`=0xE000_0000, `bus_wdata`=0xFF, `MIO_ready` next edge.
- **Abort:** write to 0xF000_0000, drop `CPU_MIO` after 1 WAIT cycle → IDLE, `bus_mem_w` never asserted, `MIO_ready` stays 0.
- **Held request:** `CPU_MIO` held high 5 cycles past ACK → `MIO_ready` high 5 cycles; no second capture until `CPU_MIO` low then high.
- **Reset during WAIT:** assert `rst` → all outputs 0 immediately; first request after release behaves as the first RAM read case.
- **Timeout (`MIO_RESP_TIMEOUT_EN`, TO_LIMIT=4):** hold `CPU_MIO` in ACK → after 4 cycles IDLE, `MIO_ready`=0, `timeout_err`=1 until `rst`.
